// File: rtl/bus_fabric.sv
// Single-master bus fabric: decodes CPU addresses onto up to 16 slave ports via a three-state IDLE/WAIT/RESP FSM.
// Define BUS_TIMEOUT_EN to build the WAIT-state timeout counter (err_code 2).
module bus_fabric #(
    parameter int          NUM_SLAVES     = 8,
    parameter logic [15:0] IO_BASE        = 16'hFFFF,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    output logic [NUM_SLAVES-1:0]    enables,
    output logic                     slave_valid,
    input  logic [NUM_SLAVES-1:0]    slave_ready,
    input  logic [32*NUM_SLAVES-1:0] slave_rdata,
    output logic                     bus_err,
    output logic [31:0]              err_addr,
    output logic [1:0]               err_code
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] ERR_UNMAPPED = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    logic [1:0]  state_reg;
    logic [3:0]  sel_reg;
    logic        err_flag_reg;
    logic [31:0] rdata_reg;
    logic [31:0] err_addr_reg;
    logic [1:0]  err_code_reg;

    // Slave ports padded out to 16 entries so a 4-bit select indexes them cleanly.
    logic [31:0] rdata_arr [16];
    logic [15:0] ready_arr;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_port
            if (gi < NUM_SLAVES) begin : g_used
                assign rdata_arr[gi] = slave_rdata[32*gi +: 32];
                assign ready_arr[gi] = slave_ready[gi];
            end else begin : g_pad
                assign rdata_arr[gi] = 32'd0;
                assign ready_arr[gi] = 1'b0;
            end
        end
    endgenerate

    logic       dec_is_io;
    logic       dec_unmapped;
    logic [3:0] dec_sel;
    logic       sel_ready;
    logic [31:0] sel_rdata;
    logic       timeout_hit;

    assign dec_is_io    = (mem_addr[31:16] == IO_BASE);
    assign dec_unmapped = dec_is_io && ({1'b0, mem_addr[7:4]} >= 5'(NUM_SLAVES));
    assign dec_sel      = dec_is_io ? mem_addr[7:4] : 4'd0;
    assign sel_ready    = ready_arr[sel_reg];
    assign sel_rdata    = rdata_arr[sel_reg];

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_reg;
    logic [31:0] addr_reg;

    // Count sits at zero in IDLE, so it is already clear on entry to WAIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= 16'd0;
            addr_reg  <= 32'd0;
        end else begin
            if (state_reg == ST_WAIT) begin
                count_reg <= count_reg + 16'd1;
            end else begin
                count_reg <= 16'd0;
            end
            if (state_reg == ST_IDLE && mem_valid) begin
                addr_reg <= mem_addr;
            end
        end
    end

    assign timeout_hit = (count_reg == TIMEOUT_LIMIT);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            sel_reg      <= 4'd0;
            err_flag_reg <= 1'b0;
            rdata_reg    <= 32'd0;
            err_addr_reg <= 32'd0;
            err_code_reg <= 2'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mem_valid) begin
                        sel_reg <= dec_sel;
                        if (dec_unmapped) begin
                            err_flag_reg <= 1'b1;
                            rdata_reg    <= ERR_RDATA;
                            err_addr_reg <= mem_addr;
                            err_code_reg <= ERR_UNMAPPED;
                            state_reg    <= ST_RESP;
                        end else begin
                            err_flag_reg <= 1'b0;
                            state_reg    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // A ready on the expiry edge takes priority over the timeout.
                    if (sel_ready) begin
                        rdata_reg    <= sel_rdata;
                        err_flag_reg <= 1'b0;
                        state_reg    <= ST_RESP;
                    end else if (timeout_hit) begin
`ifdef BUS_TIMEOUT_EN
                        err_addr_reg <= addr_reg;
`endif
                        rdata_reg    <= ERR_RDATA;
                        err_flag_reg <= 1'b1;
                        err_code_reg <= ERR_TIMEOUT;
                        state_reg    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_ready   = (state_reg == ST_RESP);
    assign bus_err     = mem_ready && err_flag_reg;
    assign slave_valid = (state_reg == ST_WAIT);
    assign mem_rdata   = rdata_reg;
    assign err_addr    = err_addr_reg;
    assign err_code    = err_code_reg;

    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_enable
            assign enables[gi] = slave_valid && (sel_reg == 4'(gi));
        end
    endgenerate

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 Parameter NUM_SLAVES, default 8, number of slave ports (2..16); slave 0 is main memory.
REQ-002 Parameter IO_BASE, default 16'hFFFF, value of mem_addr[31:16] that selects the IO region.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, WAIT-state cycle limit before a timeout error (1..65535).
REQ-004 Parameter ERR_RDATA, default 32'hDEADBEEF, read data returned on any error response.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 mem_valid  input  1  CPU request; held high until mem_ready is seen.
REQ-008 mem_addr  input  32  CPU byte address; stable while mem_valid is high.
REQ-009 mem_ready  output  1  one-cycle response strobe to the CPU.
REQ-010 mem_rdata  output  32  registered read data, valid while mem_ready is high.
REQ-011 enables  output  NUM_SLAVES  one-hot slave select.
REQ-012 slave_valid  output  1  request strobe to the selected slave.
REQ-013 slave_ready  input  NUM_SLAVES  per-slave ready flags.
REQ-014 slave_rdata  input  32*NUM_SLAVES  flat read data; slave k occupies bits [32k+31:32k].
REQ-015 bus_err  output  1  one-cycle pulse coincident with an error response.
REQ-016 err_addr  output  32  address of the most recent errored transaction.
REQ-017 err_code  output  2  cause of the last error: 0 none, 1 unmapped, 2 timeout.

Function
REQ-018 Decode: if mem_addr[31:16]==IO_BASE and mem_addr[7:4]<NUM_SLAVES, select slave mem_addr[7:4].
REQ-019 Decode: if mem_addr[31:16]==IO_BASE and mem_addr[7:4]>=NUM_SLAVES, the access is unmapped.
REQ-020 Decode: any address outside the IO region selects slave 0.
REQ-021 The FSM has exactly three states: IDLE, WAIT, RESP.
REQ-022 IDLE: on a rising edge with mem_valid high, the block registers the decode result and then moves as follows.
REQ-023 Mapped access: the FSM enters WAIT.
REQ-024 Unmapped access: the FSM enters RESP with the error flag set, so no slave is enabled.
REQ-025 WAIT: enables is one-hot on the selected slave and slave_valid is high; all other outputs are unchanged.
REQ-026 WAIT: on an edge where slave_ready[sel] is high, the block captures slave_rdata[sel] into mem_rdata and enters RESP; other slaves' ready flags are ignored.
REQ-027 RESP: mem_ready is high for exactly one cycle, enables is 0, and slave_valid is 0; the FSM then enters IDLE.
REQ-028 Latency: mem_valid high in cycle 0 gives enables in cycle 1; a ready in cycle 1 gives mem_ready in cycle 2; each extra slave wait cycle adds one cycle.
REQ-029 Latency: an unmapped access gives mem_ready in cycle 1.
REQ-030 Error response: mem_rdata=ERR_RDATA, bus_err=1 alongside mem_ready, err_addr<=mem_addr, err_code<=cause.
REQ-031 err_addr and err_code are sticky; each new error overwrites them, and they are never cleared except by reset.
REQ-032 A request arriving in IDLE in the cycle after RESP is accepted normally; no back-to-back bubble is allowed beyond the RESP cycle.
REQ-033 If mem_valid falls during WAIT, the transaction still completes; mem_valid is sampled only in IDLE.

Reset
REQ-034 While resetn is low the FSM is in IDLE and the outputs are as follows.
REQ-035 mem_ready=0, mem_rdata=0, enables=0, slave_valid=0, bus_err=0, err_addr=0, err_code=0.
REQ-036 Reset asserted mid-transaction aborts it immediately (asynchronously), with no response issued.
REQ-037 The first request is accepted on the first rising edge after resetn deasserts.

Configuration
REQ-038 Macro BUS_TIMEOUT_EN controls the WAIT-state timeout.
REQ-039 With BUS_TIMEOUT_EN defined, a 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
REQ-040 With BUS_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES without a slave ready, the FSM enters RESP with a timeout error (err_code=2).
REQ-041 With BUS_TIMEOUT_EN defined, a slave ready on the same edge as expiry wins, and the response is normal.
REQ-042 Without BUS_TIMEOUT_EN, no counter is built, WAIT lasts indefinitely, and err_code never takes the value 2.

Verification
REQ-043 Memory access: addr 0x00001000 with slave_ready[0]=1 and data 0x12345678 -> enables=0x01 in cycle 1, mem_ready with rdata 0x12345678 in cycle 2.
REQ-044 IO access: addr 0xFFFF0030 with slave 3 ready after 3 wait cycles and data 0xA5A5A5A5 -> enables=0x08 for 4 cycles, then one mem_ready, bus_err=0.
REQ-045 Unmapped access (NUM_SLAVES=4): addr 0xFFFF0050 -> mem_ready in cycle 1 with rdata 0xDEADBEEF, bus_err pulse, err_addr=0xFFFF0050, err_code=1, enables stays 0.
REQ-046 Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave 2 never ready -> 0xDEADBEEF response after 4 WAIT cycles, err_code=2.
REQ-047 Timeout tie: ready on the expiry edge -> normal data returned, no bus_err.
REQ-048 Reset mid-WAIT: resetn pulled low -> all outputs 0 at once, no mem_ready; a new request after release completes normally.
